// File: rtl/icache_fetch_unit_if.sv
// Fetch-side and memory-side signal bundle for icache_fetch_unit.
// slave is the cache view; master is the fetcher/memory-controller view.
interface icache_fetch_unit_if;
    logic        fet_icache_enable;
    logic [31:0] fet_pc;
    logic        icache_ready;
    logic [31:0] icache_inst;
    logic        icache_mem_req;
    logic [31:0] icache_mem_addr;
    logic        mem_icache_ready;
    logic [31:0] mem_icache_data;

    modport slave (
        input  fet_icache_enable,
        input  fet_pc,
        input  mem_icache_ready,
        input  mem_icache_data,
        output icache_ready,
        output icache_inst,
        output icache_mem_req,
        output icache_mem_addr
    );

    modport master (
        output fet_icache_enable,
        output fet_pc,
        output mem_icache_ready,
        output mem_icache_data,
        input  icache_ready,
        input  icache_inst,
        input  icache_mem_req,
        input  icache_mem_addr
    );
endinterface

// File: rtl/icache_fetch_unit.sv
// Direct-mapped I-cache with halfword PC support and word-at-a-time refill.
// Optional hit/miss counters enabled by defining ICACHE_STATS_EN.
module icache_fetch_unit #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    icache_fetch_unit_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]         icache_hit_cnt,
    output logic [31:0]         icache_miss_cnt
`endif
);

    localparam int NSETS = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        MISS_A,
        MISS_B,
        DRAIN
    } state_t;

    logic [31:0]      data_q [NSETS];
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [NSETS-1:0] valid_q;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [31:0] inst_q, inst_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [29:0] a_q, a_d;
    logic        hi_q, hi_d;
    logic        hit_ev, miss_ev;

    logic [29:0]            cur_a, cur_b;
    logic                   cur_hi;
    logic [INDEX_WIDTH-1:0] idx_a, idx_b, idx_f;
    logic                   hit_a, hit_b;
    logic [31:0]            word_a, word_b;
    logic [15:0]            h0;
    logic                   need_hi;
    logic [31:0]            asm_inst;
    logic                   fill;
    logic                   unused_ok;

    // In IDLE the live PC is looked up; afterwards the latched request is used.
    assign cur_a  = (state_q == IDLE) ? bus.fet_pc[31:2] : a_q;
    assign cur_hi = (state_q == IDLE) ? bus.fet_pc[1]    : hi_q;
    assign cur_b  = cur_a + 30'd1;
    assign idx_a  = cur_a[INDEX_WIDTH-1:0];
    assign idx_b  = cur_b[INDEX_WIDTH-1:0];
    assign hit_a  = valid_q[idx_a] && (tag_q[idx_a] == cur_a[29:INDEX_WIDTH]);
    assign hit_b  = valid_q[idx_b] && (tag_q[idx_b] == cur_b[29:INDEX_WIDTH]);

    // Returning refill data bypasses the array for the word in flight.
    assign word_a = (state_q == MISS_A) ? bus.mem_icache_data : data_q[idx_a];
    assign word_b = (state_q == MISS_B) ? bus.mem_icache_data : data_q[idx_b];

    assign h0      = cur_hi ? word_a[31:16] : word_a[15:0];
    assign need_hi = cur_hi && (h0[1:0] == 2'b11);

    always_comb begin
        asm_inst = {16'b0, h0};
        if (h0[1:0] == 2'b11) begin
            asm_inst = cur_hi ? {word_b[15:0], h0} : word_a;
        end
    end

    assign fill  = bus.mem_icache_ready &&
                   (state_q == MISS_A || state_q == MISS_B || state_q == DRAIN);
    assign idx_f = addr_q[INDEX_WIDTH+1:2];

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        inst_d  = inst_q;
        req_d   = req_q;
        addr_d  = addr_q;
        a_d     = a_q;
        hi_d    = hi_q;
        hit_ev  = 1'b0;
        miss_ev = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.fet_icache_enable && !flush) begin
                    a_d  = cur_a;
                    hi_d = cur_hi;
                    if (!hit_a) begin
                        state_d = MISS_A;
                        req_d   = 1'b1;
                        addr_d  = {cur_a, 2'b00};
                        miss_ev = 1'b1;
                    end else if (need_hi && !hit_b) begin
                        state_d = MISS_B;
                        req_d   = 1'b1;
                        addr_d  = {cur_b, 2'b00};
                        miss_ev = 1'b1;
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        inst_d  = asm_inst;
                        hit_ev  = 1'b1;
                    end
                end
            end
            RESP: state_d = IDLE;
            MISS_A: begin
                if (bus.mem_icache_ready) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else if (need_hi && !hit_b) begin
                        state_d = MISS_B;
                        req_d   = 1'b1;
                        addr_d  = {cur_b, 2'b00};
                        miss_ev = 1'b1;
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        inst_d  = asm_inst;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            MISS_B: begin
                if (bus.mem_icache_ready) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        inst_d  = asm_inst;
                    end
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_icache_ready) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            inst_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            a_q     <= '0;
            hi_q    <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            inst_q  <= inst_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            a_q     <= a_d;
            hi_q    <= hi_d;
            if (fill) begin
                valid_q[idx_f] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[idx_f] <= bus.mem_icache_data;
            tag_q[idx_f]  <= addr_q[31:INDEX_WIDTH+2];
        end
    end

    // A flush in the response cycle suppresses the pulse the fetcher would see.
    assign bus.icache_ready    = ready_q && !flush;
    assign bus.icache_inst     = inst_q;
    assign bus.icache_mem_req  = req_q;
    assign bus.icache_mem_addr = addr_q;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icache_hit_cnt  <= '0;
            icache_miss_cnt <= '0;
        end else begin
            if (hit_ev) begin
                icache_hit_cnt <= icache_hit_cnt + 32'd1;
            end
            if (miss_ev) begin
                icache_miss_cnt <= icache_miss_cnt + 32'd1;
            end
        end
    end

    assign unused_ok = ^{bus.fet_pc[0], word_b[31:16]};
`else
    assign unused_ok = ^{bus.fet_pc[0], word_b[31:16], hit_ev, miss_ev};
`endif

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Directed and randomized checks of icache_fetch_unit against a
// behavioural cache/memory model.
module tb_icache_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    icache_fetch_unit_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    icache_fetch_unit #(.INDEX_WIDTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .icache_hit_cnt  (hit_cnt),
        .icache_miss_cnt (miss_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [29:0]];
    logic [29:0] line_tag [64];
    bit          line_v   [64];
    logic [31:0] req_log [$];
    logic [31:0] exp_log [$];
    int          force_delay = -1;
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] memword(logic [29:0] wa);
        if (mem.exists(wa)) return mem[wa];
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit mhit(logic [29:0] wa);
        return line_v[wa[5:0]] && line_tag[wa[5:0]] == wa;
    endfunction

    function automatic void install(logic [29:0] wa);
        line_v[wa[5:0]]   = 1'b1;
        line_tag[wa[5:0]] = wa;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) line_v[i] = 1'b0;
    endtask

    task automatic model_fetch(input logic [31:0] pc, output logic [31:0] inst);
        logic [29:0] a, b;
        logic [31:0] wa, wb;
        logic [15:0] h0;
        exp_log.delete();
        a  = pc[31:2];
        b  = a + 30'd1;
        wa = memword(a);
        if (!mhit(a)) begin
            exp_log.push_back({a, 2'b00});
            install(a);
        end
        h0 = pc[1] ? wa[31:16] : wa[15:0];
        if (h0[1:0] != 2'b11) begin
            inst = {16'h0000, h0};
        end else if (!pc[1]) begin
            inst = wa;
        end else begin
            if (!mhit(b)) begin
                exp_log.push_back({b, 2'b00});
                install(b);
            end
            wb   = memword(b);
            inst = {wb[15:0], h0};
        end
        if (exp_log.size() == 0) exp_hits++;
        exp_misses += exp_log.size();
    endtask

    task automatic fetch(input logic [31:0] pc, input string tag);
        logic [31:0] ei;
        int cyc;
        bit got;
        model_fetch(pc, ei);
        @(negedge clk);
        req_log.delete();
        bus.fet_pc = pc;
        bus.fet_icache_enable = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            got = bus.icache_ready;
        end
        bus.fet_icache_enable = 1'b0;
        check({tag, "_ready"}, 32'(got), 32'd1);
        check({tag, "_inst"}, bus.icache_inst, ei);
        check({tag, "_nreq"}, req_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < req_log.size()) check({tag, "_addr"}, req_log[i], exp_log[i]);
        end
        if (exp_log.size() == 0) check({tag, "_lat"}, cyc, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.icache_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.fet_icache_enable = 1'b0;
        bus.fet_pc = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Memory controller: answers each pending word request after a short delay.
    initial begin
        int d;
        bus.mem_icache_ready = 1'b0;
        bus.mem_icache_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_icache_ready = 1'b0;
            if (rst_n === 1'b1 && bus.icache_mem_req === 1'b1) begin
                d = force_delay >= 0 ? force_delay : int'($urandom_range(0, 2));
                repeat (d) @(negedge clk);
                bus.mem_icache_data  = memword(bus.icache_mem_addr[31:2]);
                bus.mem_icache_ready = 1'b1;
                req_log.push_back(bus.icache_mem_addr);
            end
        end
    end

    initial begin
        bit seen_ready;
        bit req_low_early;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.fet_icache_enable = 1'b0;
        bus.fet_pc = '0;
        model_clear();
        #1;
        check("rst_ready", 32'(bus.icache_ready), 32'd0);
        check("rst_inst", bus.icache_inst, 32'd0);
        check("rst_req", 32'(bus.icache_mem_req), 32'd0);
        check("rst_addr", bus.icache_mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        mem[30'h0] = 32'h0050_0093;
        fetch(32'h0, "cold");
        fetch(32'h0, "hit");

        do_reset();
        mem[30'h0] = 32'h4501_0001;
        fetch(32'h2, "c_hi");
        fetch(32'h0, "c_lo");

        mem[30'h1] = 32'h0093_ABCD;
        mem[30'h2] = 32'h1234_0050;
        fetch(32'h6, "straddle");
        fetch(32'h6, "straddle_hit");

        // Flush while the refill for 0x40 is outstanding.
        install(30'h10);
        exp_misses++;
        force_delay = 4;
        @(negedge clk);
        req_log.delete();
        bus.fet_pc = 32'h40;
        bus.fet_icache_enable = 1'b1;
        @(negedge clk);
        check("flush_req", 32'(bus.icache_mem_req), 32'd1);
        flush = 1'b1;
        bus.fet_icache_enable = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        seen_ready = 1'b0;
        req_low_early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.icache_ready) seen_ready = 1'b1;
            if (req_log.size() == 0 && !bus.icache_mem_req) req_low_early = 1'b1;
        end
        force_delay = -1;
        check("flush_noready", 32'(seen_ready), 32'd0);
        check("flush_req_held", 32'(req_low_early), 32'd0);
        check("flush_nreq", req_log.size(), 32'd1);
        if (req_log.size() > 0) check("flush_addr", req_log[0], 32'h40);
        check("flush_req_drop", 32'(bus.icache_mem_req), 32'd0);
        fetch(32'h40, "flush_refetch");

        mem[30'h40] = 32'hCAFE_0013;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0, "conf0");
            fetch(32'h100, "conf1");
        end

        mem[30'h3FFF_FFFF] = 32'h1237_BEEF;
        fetch(32'hFFFF_FFFE, "wrap");
        fetch(32'hFFFF_FFFE, "wrap_hit");

        for (int w = 12'h400; w < 12'h600; w++) mem[30'(w)] = $urandom;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] pc;
            pc = (32'h1000 + $urandom_range(0, 32'h7FF)) & 32'hFFFF_FFFE;
            fetch(pc, "rand");
        end

`ifdef ICACHE_STATS_EN
        check("stat_hits", hit_cnt, exp_hits);
        check("stat_misses", miss_cnt, exp_misses);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
Direct-mapped instruction cache directly upstream of the fetcher. Accepts fetch requests on fet_pc and returns one assembled instruction per request: a 32-bit instruction, or a 16-bit C-extension instruction zero-extended to 32 bits. Handles halfword-aligned PCs, including 32-bit instructions that straddle two words. Refills misses from the memory controller one 32-bit word at a time.

Parameters:
INDEX_WIDTH, 6, log2 of word entries; 64 words = 256 B. Tag width = 30 - INDEX_WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
flush  input  1  from ROB; abort current request
fet_icache_enable  input  1  request valid; fet_pc held stable until icache_ready
fet_pc  input  32  fetch address; bit 0 ignored
icache_ready  output  1  one-cycle pulse; icache_inst valid
icache_inst  output  32  assembled instruction
icache_mem_req  output  1  word read request, level, held until mem_icache_ready
icache_mem_addr  output  32  word-aligned read address
mem_icache_ready  input  1  one-cycle pulse; mem_icache_data valid
mem_icache_data  input  32  returned word

Behaviour:
- Reset (async, rst_n=0): all valid bits cleared; state IDLE; icache_ready=0, icache_inst=0, icache_mem_req=0, icache_mem_addr=0. Data and tag arrays are not reset. Reset mid-miss abandons the request; the memory controller shares rst_n.
- Address split: word A = fet_pc[31:2], index = A[INDEX_WIDTH-1:0], tag = A[31:INDEX_WIDTH+2 of pc]. Word B = A+1, wrapping mod 2^30 (pc 0xFFFFFFFE -> B address 0x0).
- Halfword select: h0 = pc[1] ? A[31:16] : A[15:0]. need_hi = pc[1] && h0[1:0]==2'b11.
- Assembly:
  - h0[1:0]!=11: inst = {16'b0, h0}.
  - pc[1]=0 and h0[1:0]==11: inst = full word A.
  - need_hi: inst = {B[15:0], h0}.
- States: IDLE, RESP, MISS_A, MISS_B, DRAIN.
- IDLE: when enable && !flush, look up A (and B if need_hi).
  - All needed words hit: register inst, icache_ready=1 next cycle, go to RESP. Hit latency = 1 cycle.
  - A misses: go to MISS_A, assert req with addr {A,2'b00}.
  - A hits, need_hi, and B misses: go to MISS_B, assert req with addr {B,2'b00}.
- RESP: icache_ready deasserts next cycle; enable is ignored this cycle (the requester updates pc on this edge). Return to IDLE. Throughput is 1 instruction per 2 cycles on hits.
- MISS_A: hold req/addr. On mem_icache_ready:
  - Write data/tag/valid for A; drop req.
  - Recompute need_hi from the returned data.
  - need_hi and B misses: MISS_B. Otherwise: respond (icache_ready=1 next cycle) and go to RESP.
- MISS_B: on mem_icache_ready, fill B, respond, go to RESP.
- flush:
  - In IDLE/RESP: no response next cycle; icache_ready forced 0; go to IDLE.
  - In MISS_A/MISS_B: go to DRAIN.
  - In DRAIN: no effect.
- DRAIN: hold req until mem_icache_ready, write the fill, assert no response, go to IDLE.
- flush and mem_icache_ready in the same cycle: the fill is written, no response, go to IDLE.
- A and B mapping to the same index (INDEX_WIDTH=0 only) is not supported.
- A fill overwrites the existing entry (no replacement choice).

Optional Feature:
ICACHE_STATS_EN:
- Defined: adds output ports icache_hit_cnt[31:0] and icache_miss_cnt[31:0], reset to 0 and wrapping.
  - hit_cnt increments once per response served without a mem request.
  - miss_cnt increments once per mem request issued, including DRAIN.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Cold aligned: reset, enable, pc=0x0.
   - Expect req addr 0x0; mem returns 0x00500093.
   - Expect icache_ready pulse with inst=0x00500093.
   - Repeat pc=0x0: hit, ready exactly 1 cycle after sampling, no req.
2. Compressed: word@0x0=0x45010001, pc=0x2 -> inst=0x00004501, single req (or hit if cached); pc=0x0 -> inst=0x00000001.
3. Straddle:
   - Words @0x4=0x0093ABCD and @0x8=0x12340050; pc=0x6.
   - Expect reqs to 0x4 then 0x8; inst=0x00500093.
   - Re-fetch pc=0x6: hit in 1 cycle.
4. Flush in MISS_A:
   - pc=0x40 miss; flush while req is pending.
   - req stays high until mem_ready; no icache_ready.
   - Next request pc=0x40 hits.
5. Conflict: alternate pc=0x0 / 0x100 (INDEX_WIDTH=6) -> every access misses; returned data always matches its own address.
6. Wrap: pc=0xFFFFFFFE with word upper half ending 11 -> second req addr 0x00000000; correct assembled inst.
